// File: rtl/rom_sync_mc.sv
// rtl/rom_sync_mc.sv - multi-channel synchronous lookup ROM with fixed read latency
//
// Purpose:
//   Several independent read channels share one block-RAM table image. Each
//   channel presents an address with a request strobe. The result appears
//   exactly LATENCY cycles later, together with a one-cycle valid strobe.
//   With QUARTER=1 the table holds one quarter period of a periodic waveform,
//   and the full period is rebuilt by mirroring the index and inverting the
//   output.
//
// Ports:
//   clk_in     in   1                 clock, all state changes on rising edge
//   rst_n_in   in   1                 synchronous reset, active low
//   en_in      in   CHANNELS          per-channel read request
//   addr_in    in   CHANNELS*ADDRW    channel c address at [c*ADDRW +: ADDRW]
//   data_out   out  CHANNELS*WIDTH    channel c result at [c*WIDTH +: WIDTH]
//   valid_out  out  CHANNELS          per-channel result strobe

module rom_sync_mc #(
  parameter int    WIDTH    = 8,
  parameter int    DEPTH    = 256,
  parameter int    CHANNELS = 2,
  parameter int    LATENCY  = 2,
  parameter int    QUARTER  = 0,
  parameter string INIT_F   = "sine_lut.mem",
  parameter int    ADDRW    = $clog2(DEPTH)
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [CHANNELS-1:0]          en_in,
  input  logic [CHANNELS*ADDRW-1:0]    addr_in,
  output logic [CHANNELS*WIDTH-1:0]    data_out,
  output logic [CHANNELS-1:0]          valid_out
);

  // In quarter mode the top two address bits select the quadrant, so the
  // table only needs to cover the remaining index bits.
  localparam int IDXW = (QUARTER != 0) ? ADDRW - 2 : ADDRW;
  localparam int MEMD = 1 << IDXW;

  // Illegal parameter combinations stop elaboration.
  if (DEPTH < 8) begin : g_chk_depth_min
    $fatal(1, "rom_sync_mc: DEPTH must be at least 8");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth_pow2
    $fatal(1, "rom_sync_mc: DEPTH must be a power of two");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_chk_latency
    $fatal(1, "rom_sync_mc: LATENCY must be 1 to 4");
  end
  if (QUARTER != 0 && LATENCY < 2) begin : g_chk_quarter
    $fatal(1, "rom_sync_mc: QUARTER=1 requires LATENCY >= 2");
  end
  if (CHANNELS < 1) begin : g_chk_channels
    $fatal(1, "rom_sync_mc: CHANNELS must be at least 1");
  end

  // Read-only table. Never reset.
  logic [WIDTH-1:0] mem [MEMD];

  initial begin
    for (int i = 0; i < MEMD; i++) begin
      mem[i] = '0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ADDRW-1:0]  addr;
    logic [IDXW-1:0]   rd_idx;
    logic              flip;
    logic [LATENCY-1:0] v;
    logic [WIDTH-1:0]  d [LATENCY];
    logic              inv;

    assign addr = addr_in[c*ADDRW +: ADDRW];

    if (QUARTER != 0) begin : g_quarter
      // Odd quadrants run the quarter table backwards; the mirror happens
      // on the index so the memory sees an ordinary address. The upper
      // quadrant bit requests the output reflection about mid-scale.
      assign rd_idx = addr[ADDRW-2] ? ~addr[IDXW-1:0] : addr[IDXW-1:0];
      assign flip   = addr[ADDRW-1];
    end else begin : g_full
      assign rd_idx = addr;
      assign flip   = 1'b0;
    end

    always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
        v   <= '0;
        inv <= 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
          d[k] <= '0;
        end
      end else begin
        // Stage 1: registered memory read. Data and the invert flag only
        // load on a request so an idle channel keeps its last result.
        v[0] <= en_in[c];
        if (en_in[c]) begin
          d[0] <= mem[rd_idx];
          inv  <= flip;
        end
        // Later stages: valid shifts every cycle, data follows valid.
        // The quadrant inversion is applied entering stage 2, keeping the
        // XOR out of the memory-output timing path.
        for (int k = 1; k < LATENCY; k++) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            d[k] <= (k == 1) ? (d[0] ^ {WIDTH{inv}}) : d[k-1];
          end
        end
      end
    end

    assign data_out[c*WIDTH +: WIDTH] = d[LATENCY-1];
    assign valid_out[c]               = v[LATENCY-1];
  end

endmodule

// File: tb/tb_rom_sync_mc.sv
// tb/tb_rom_sync_mc.sv - directed self-checking bench for rom_sync_mc

module tb_rom_sync_mc;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [1:0]  f_en,    s_en,    q_en;
  logic [15:0] f_addr,  s_addr,  q_addr;
  logic [15:0] f_data,  s_data,  q_data;
  logic [1:0]  f_valid, s_valid, q_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Full mode, latency 2
  rom_sync_mc #(
    .WIDTH(8), .DEPTH(256), .CHANNELS(2), .LATENCY(2), .QUARTER(0), .INIT_F("")
  ) u_full (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(f_en), .addr_in(f_addr),
    .data_out(f_data), .valid_out(f_valid)
  );

  // Full mode, latency 3 (streaming)
  rom_sync_mc #(
    .WIDTH(8), .DEPTH(256), .CHANNELS(2), .LATENCY(3), .QUARTER(0), .INIT_F("")
  ) u_strm (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(s_en), .addr_in(s_addr),
    .data_out(s_data), .valid_out(s_valid)
  );

  // Quarter mode, latency 2
  rom_sync_mc #(
    .WIDTH(8), .DEPTH(256), .CHANNELS(2), .LATENCY(2), .QUARTER(1), .INIT_F("")
  ) u_qtr (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(q_en), .addr_in(q_addr),
    .data_out(q_data), .valid_out(q_valid)
  );

  task automatic load_images();
    for (int i = 0; i < 256; i++) begin
      u_full.mem[i] = 8'(i);
      u_strm.mem[i] = 8'(i);
    end
    for (int i = 0; i < 64; i++) begin
      u_qtr.mem[i] = 8'(2 * i);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    f_en = 2'b11; s_en = 2'b11; q_en = 2'b11;
    f_addr = 16'h1010; s_addr = 16'h1010; q_addr = 16'h1010;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checks++;
      if ({f_valid, s_valid, q_valid} !== 6'b0) begin
        errors++;
        $display("FAIL reset_valid cyc %0d: got %b expected 000000", t, {f_valid, s_valid, q_valid});
      end
      checks++;
      if ({f_data, s_data, q_data} !== 48'h0) begin
        errors++;
        $display("FAIL reset_data cyc %0d: got %h expected 0", t, {f_data, s_data, q_data});
      end
    end
    rst_n = 1'b1;
    f_en = 2'b00; s_en = 2'b00; q_en = 2'b00;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checks++;
      if ({f_valid, s_valid, q_valid} !== 6'b0 || {f_data, s_data, q_data} !== 48'h0) begin
        errors++;
        $display("FAIL reset_release cyc %0d: got valid %b data %h expected 0/0",
                 t, {f_valid, s_valid, q_valid}, {f_data, s_data, q_data});
      end
    end
  endtask

  task automatic test_basic();
    f_en = 2'b11; f_addr = {8'hFF, 8'h05};
    @(negedge clk);
    f_en = 2'b00; f_addr = 16'h0000;
    checks++;
    if (f_valid !== 2'b00) begin
      errors++;
      $display("FAIL basic_early_valid: got %b expected 00", f_valid);
    end
    @(negedge clk);
    checks++;
    if (f_valid !== 2'b11) begin
      errors++;
      $display("FAIL basic_valid: got %b expected 11", f_valid);
    end
    checks++;
    if (f_data !== 16'hFF05) begin
      errors++;
      $display("FAIL basic_data: got %h expected ff05", f_data);
    end
    @(negedge clk);
    checks++;
    if (f_valid !== 2'b00 || f_data !== 16'hFF05) begin
      errors++;
      $display("FAIL basic_pulse: got valid %b data %h expected 00 ff05", f_valid, f_data);
    end
  endtask

  task automatic test_stream();
    int k;
    for (int t = 0; t < 262; t++) begin
      @(negedge clk);
      k = t - 3;
      if (k >= 0 && k < 256) begin
        checks++;
        if (s_valid !== 2'b01 || s_data[7:0] !== 8'(k)) begin
          errors++;
          $display("FAIL stream_word %0d: got valid %b data %h expected 01 %h",
                   k, s_valid, s_data[7:0], 8'(k));
        end
      end else if (t >= 3) begin
        checks++;
        if (s_valid !== 2'b00) begin
          errors++;
          $display("FAIL stream_tail cyc %0d: got valid %b expected 00", t, s_valid);
        end
      end
      s_en   = (t < 256) ? 2'b01 : 2'b00;
      s_addr = {8'h00, 8'(t)};
    end
  endtask

  task automatic test_quarter();
    logic [7:0] a0 [4];
    logic [7:0] a1 [4];
    logic [7:0] e0 [4];
    logic [7:0] e1 [4];
    a0 = '{8'h05, 8'h45, 8'h85, 8'hC5};
    e0 = '{8'h0A, 8'h74, 8'hF5, 8'h8B};
    a1 = '{8'hC5, 8'h85, 8'h45, 8'h05};
    e1 = '{8'h8B, 8'hF5, 8'h74, 8'h0A};
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      if (t >= 2 && t < 6) begin
        checks++;
        if (q_valid !== 2'b11 || q_data !== {e1[t-2], e0[t-2]}) begin
          errors++;
          $display("FAIL quarter_word %0d: got valid %b data %h expected 11 %h",
                   t - 2, q_valid, q_data, {e1[t-2], e0[t-2]});
        end
      end else if (t == 6) begin
        checks++;
        if (q_valid !== 2'b00) begin
          errors++;
          $display("FAIL quarter_tail: got valid %b expected 00", q_valid);
        end
      end
      if (t < 4) begin
        q_en = 2'b11; q_addr = {a1[t], a0[t]};
      end else begin
        q_en = 2'b00; q_addr = 16'h0000;
      end
    end
  endtask

  task automatic test_reset_mid();
    f_en = 2'b01; f_addr = 16'h0033;
    @(negedge clk);
    f_en = 2'b00; f_addr = 16'h0000; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 2; t < 5; t++) begin
      checks++;
      if (f_valid !== 2'b00 || f_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: got valid %b data %h expected 00 0000", t, f_valid, f_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    f_en = 2'b11; f_addr = {8'h07, 8'h20};
    @(negedge clk);
    f_en = 2'b00; f_addr = 16'hA5C3;
    @(negedge clk);
    checks++;
    if (f_valid !== 2'b11 || f_data !== 16'h0720) begin
      errors++;
      $display("FAIL hold_read: got valid %b data %h expected 11 0720", f_valid, f_data);
    end
    for (int t = 0; t < 10; t++) begin
      f_addr = 16'(t * 16'h1357);
      @(negedge clk);
      checks++;
      if (f_valid !== 2'b00 || f_data !== 16'h0720) begin
        errors++;
        $display("FAIL hold_idle cyc %0d: got valid %b data %h expected 00 0720", t, f_valid, f_data);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    f_en = 2'b00; s_en = 2'b00; q_en = 2'b00;
    f_addr = '0; s_addr = '0; q_addr = '0;
    #1;
    load_images();
    test_reset();
    test_basic();
    test_stream();
    test_quarter();
    test_reset_mid();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
